// File: rtl/bitstream_bcd_counter.sv
// Counts the 1s of a stochastic bitstream over WINDOW_LEN enabled cycles and
// converts each completed count to packed BCD with a sequential double-dabble engine.
module bitstream_bcd_counter #(
  parameter int WINDOW_LEN = 1000,
  parameter int COUNT_W    = $clog2(WINDOW_LEN + 1),
  parameter int DIGITS     = 4
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  bit_in,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  digits_valid,
  output logic                  busy
);

  localparam int ITER_W = $clog2(COUNT_W + 1);
  localparam logic [COUNT_W-1:0] LAST_CYCLE = COUNT_W'(WINDOW_LEN - 1);
  localparam logic [ITER_W-1:0]  LAST_ITER  = ITER_W'(COUNT_W - 1);

  if (10**DIGITS <= WINDOW_LEN) begin : g_chk_digits
    $error("DIGITS too small to display WINDOW_LEN");
  end
  if (WINDOW_LEN < COUNT_W + 2) begin : g_chk_window
    $error("WINDOW_LEN must be at least COUNT_W+2");
  end

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t                r_state, w_state_nxt;
  logic [COUNT_W-1:0]    r_cycle_cnt, r_ones_cnt, r_shift, w_shift_nxt;
  logic [4*DIGITS-1:0]   r_bcd, r_digits, w_bcd_adj, w_bcd_nxt;
  logic [ITER_W-1:0]     r_iter;
  logic                  r_digits_valid;
  logic                  w_window_end, w_last_iter;

  function automatic logic [4*DIGITS-1:0] f_add3(input logic [4*DIGITS-1:0] bcd);
    logic [4*DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  assign w_window_end = enable && (r_cycle_cnt == LAST_CYCLE);
  assign w_last_iter  = (r_state == S_CONVERT) && (r_iter == LAST_ITER);
  assign w_bcd_adj    = f_add3(r_bcd);
  assign {w_bcd_nxt, w_shift_nxt} = {w_bcd_adj, r_shift} << 1;

  // A window end can never land inside CONVERT, so the two branches never compete.
  always_comb begin
    w_state_nxt = r_state;
    if (clear)             w_state_nxt = S_IDLE;
    else if (w_window_end) w_state_nxt = S_CONVERT;
    else if (w_last_iter)  w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_cycle_cnt <= '0;
      r_ones_cnt  <= '0;
    end else if (clear) begin
      r_cycle_cnt <= '0;
      r_ones_cnt  <= '0;
    end else if (enable) begin
      if (w_window_end) begin
        r_cycle_cnt <= '0;
        r_ones_cnt  <= '0;
      end else begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
        r_ones_cnt  <= r_ones_cnt + COUNT_W'(bit_in);
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_iter         <= '0;
      r_digits       <= '0;
      r_digits_valid <= 1'b0;
    end else begin
      r_digits_valid <= 1'b0;
      if (!clear) begin
        if (w_window_end) begin
          r_iter <= '0;
        end else if (r_state == S_CONVERT) begin
          r_iter <= r_iter + 1'b1;
          if (w_last_iter) begin
            r_digits       <= w_bcd_nxt;
            r_digits_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Conversion datapath: the snapshot is loaded straight into the low half of the shifter.
  always_ff @(posedge clock) begin
    if (!clear && w_window_end) begin
      r_shift <= r_ones_cnt + COUNT_W'(bit_in);
      r_bcd   <= '0;
    end else if (r_state == S_CONVERT) begin
      r_shift <= w_shift_nxt;
      r_bcd   <= w_bcd_nxt;
    end
  end

  assign digits       = r_digits;
  assign digits_valid = r_digits_valid;
  assign busy         = (r_state == S_CONVERT);

endmodule

// File: tb/tb_bitstream_bcd_counter.sv
// Scoreboard bench: a cycle model pushes expected BCD results at each window end;
// a negedge monitor pops and compares them when digits_valid fires.
module tb_bitstream_bcd_counter;

  localparam int WINDOW_LEN = 1000;
  localparam int COUNT_W    = 10;
  localparam int DIGITS     = 4;

  logic                clock = 1'b0;
  logic                n_reset = 1'b0;
  logic                enable = 1'b0;
  logic                clear = 1'b0;
  logic                bit_in = 1'b0;
  logic [4*DIGITS-1:0] digits;
  logic                digits_valid;
  logic                busy;

  bitstream_bcd_counter #(
    .WINDOW_LEN(WINDOW_LEN),
    .COUNT_W   (COUNT_W),
    .DIGITS    (DIGITS)
  ) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .enable      (enable),
    .clear       (clear),
    .bit_in      (bit_in),
    .digits      (digits),
    .digits_valid(digits_valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  int          m_ones = 0;
  int          n_valid = 0;
  int          busy_run = 0;
  logic [15:0] last_digits = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic b, input logic clr);
    exp_t x;
    enable = en;
    bit_in = b;
    clear  = clr;
    @(posedge clock);
    #1;
    cyc++;
    if (clr) begin
      m_cnt  = 0;
      m_ones = 0;
      if (q.size() > 0) q.pop_back();
    end else if (en) begin
      if (m_cnt == WINDOW_LEN - 1) begin
        x.d   = to_bcd(m_ones + int'(b));
        x.due = cyc + COUNT_W;
        q.push_back(x);
        m_cnt  = 0;
        m_ones = 0;
      end else begin
        m_cnt++;
        m_ones += int'(b);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    n_reset = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_ones = 0;
    last_digits = '0;
    #1;
    check_val("rst_async_digits", digits, 16'h0000);
    check_val("rst_async_valid", digits_valid, 1'b0);
    check_val("rst_async_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    cyc++;
    n_reset = 1'b1;
  endtask

  always @(negedge clock) begin
    if (busy) begin
      busy_run++;
    end else begin
      if (digits_valid) begin
        n_valid++;
        check_val("busy_len", busy_run, COUNT_W);
        check_val("valid_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check_val("digits", digits, e.d);
          check_val("latency", cyc, e.due);
          last_digits = e.d;
        end
      end
      busy_run = 0;
    end
    if (q.size() > 0 && cyc > q[0].due) begin
      check_val("valid_timeout", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  initial begin
    int v0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_digits", digits, 16'h0000);
    check_val("reset_valid", digits_valid, 1'b0);
    check_val("reset_busy", busy, 1'b0);
    n_reset = 1'b1;

    // all zeros
    v0 = n_valid;
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, 1'b0, 1'b0);
    idle(15);
    check_val("zeros_one_pulse", n_valid - v0, 1);

    // all ones, two back-to-back windows
    v0 = n_valid;
    for (int i = 0; i < 2 * WINDOW_LEN; i++) step(1'b1, 1'b1, 1'b0);
    idle(15);
    check_val("ones_two_pulses", n_valid - v0, 2);
    check_val("ones_digits", digits, 16'h1000);

    // 1,0,0 and 1,0 patterns
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 3) == 0, 1'b0);
    idle(15);
    check_val("p100_digits", digits, 16'h0334);
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 2) == 0, 1'b0);
    idle(15);
    check_val("p10_digits", digits, 16'h0500);

    // enable low for 200 cycles with bit_in high
    for (int i = 0; i < WINDOW_LEN; i++) begin
      if (i == 500) for (int k = 0; k < 200; k++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, i < 37, 1'b0);
    end
    idle(15);
    check_val("pause_digits", digits, 16'h0037);

    // clear during conversion aborts it
    v0 = n_valid;
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 4) == 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(20);
    check_val("clear_no_pulse", n_valid - v0, 0);
    check_val("clear_hold_digits", digits, last_digits);
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 5) == 0, 1'b0);
    idle(15);
    check_val("after_clear_digits", digits, 16'h0200);

    // clear on the window-end edge: no snapshot
    v0 = n_valid;
    for (int i = 0; i < WINDOW_LEN - 1; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(20);
    check_val("clear_at_end_no_pulse", n_valid - v0, 0);
    check_val("clear_at_end_busy", busy, 1'b0);

    // reset mid-window, then mid-conversion
    for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b0);
    pulse_reset();
    v0 = n_valid;
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    pulse_reset();
    idle(20);
    check_val("rst_conv_no_pulse", n_valid - v0, 0);
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 7) == 0, 1'b0);
    idle(15);
    check_val("after_rst_digits", digits, 16'h0143);
    check_val("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
